att_autorange_ctrl: RTL and testbench
=====================================

# att_autorange_ctrl

Automatic ranging controller for the B-channel input attenuator. It measures the peak magnitude of the ADC stream over a fixed window and steps the 4-bit attenuation index up or down with hysteresis. After every change it waits for the relays and the serial update to settle before measuring again. `o_att_idx` drives the `i_ATT_B` input of the HC595 attenuator serializer directly downstream; index 0 means no attenuation and index 9 means maximum (60 dB).

## Interface
Parameters:
- `ADC_W`, 12: ADC sample width, signed two's complement.
- `WIN_LEN`, 4096: valid samples per measurement window, ≥ 2.
- `SETTLE_CYC`, 100000: clocks to wait after any index change, ≥ 1.
- `HI_TH`, 1843: peak ≥ HI_TH requests more attenuation (about 90% FS).
- `LO_TH`, 737: peak < LO_TH requests less attenuation (about 36% FS). LO_TH < HI_TH is required.
- `CLIP_TH`, 2040: any single |sample| ≥ CLIP_TH aborts the window.
- `MAX_IDX`, 9: highest legal index.

Ports:
- `i_clk`, in, 1: single clock. Every register is on the rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_en`, in, 1: enables auto-ranging. When low, the FSM sits in IDLE and the index holds.
- `i_adc_valid`, in, 1: sample strobe, at most one per clock.
- `i_adc_data`, in, ADC_W: signed sample.
- `i_force`, in, 1: manual override.
- `i_force_idx`, in, 4: manual index. Values above MAX_IDX clamp to MAX_IDX.
- `o_att_idx`, out, 4: registered attenuation index, connected to `i_ATT_B`.
- `o_locked`, out, 1: the last completed window was in range and caused no change.
- `o_range_err`, out, 1: the window wanted a step beyond 0 or MAX_IDX.
- `o_peak`, out, ADC_W-1: peak magnitude of the last completed window.

## Operation
- Magnitude: `|x|` with a 1-cycle register stage. The most negative code saturates to 2^(ADC_W-1)-1.
- States:
  - IDLE → SETTLE when `i_en` = 1.
  - SETTLE: count SETTLE_CYC clocks and ignore samples. Then go to MEASURE with the peak and sample counter cleared.
  - MEASURE: per valid sample, peak ← max(peak, |x|) and count+1.
    - Count reaches WIN_LEN → DECIDE.
    - |x| ≥ CLIP_TH → DECIDE immediately with the clip flag set.
  - DECIDE, one clock:
    - clip or peak ≥ HI_TH: if idx < MAX_IDX, idx+1 → SETTLE; otherwise set range_err → MEASURE.
    - peak < LO_TH: if idx > 0, idx−1 → SETTLE; otherwise set range_err → MEASURE.
    - Otherwise set locked, clear range_err → MEASURE.
- Only one step is allowed per decision. There is never a jump of more than 1.
- `o_locked` clears on any index change, on force, and when `i_en` falls. `o_range_err` is sticky until an in-range decision or reset.
- `o_peak` updates only in DECIDE. It is the saturated window peak, or the clipping sample on an abort.
- Force has priority over every state:
  - While `i_force` = 1: `o_att_idx` = clamp(`i_force_idx`), the FSM is held in SETTLE with the counter reloaded, and locked = 0.
  - When force falls, a full SETTLE runs, then auto-ranging resumes from the forced index.
- `i_en` falling mid-window: return to IDLE next clock, discard the partial window, keep the index, clear locked.
- Reset mid-operation: all state and outputs go to reset values immediately. No partial update is allowed.

## Timing
- Reset values: `o_att_idx` = MAX_IDX (safe maximum attenuation), `o_locked` = 0, `o_range_err` = 0, `o_peak` = 0, FSM = IDLE, counters = 0.
- Latency from the last window sample at the input to the `o_att_idx` change is 3 clocks: abs stage, compare/DECIDE, output register.
- Clip abort latency is the same 3 clocks from the offending sample.
- SETTLE begins the clock `o_att_idx` changes and lasts exactly SETTLE_CYC clocks. It must exceed the downstream serial update time of about 20 clocks plus relay time.
- Force takes effect on `o_att_idx` 1 clock after `i_force` is sampled high.
- Samples arriving in IDLE, SETTLE or DECIDE are dropped. A sample already in the abs stage when DECIDE fires is also dropped.
- Counter widths: clog2(WIN_LEN+1) and clog2(SETTLE_CYC+1). No wrap is possible.

## Structure
- Shared package `imp_pkg` holds:
  - the FSM state enum `att_ar_state_t` (IDLE, SETTLE, MEASURE, DECIDE);
  - `ATT_IDX_W` = 4 and `ATT_MAX_IDX` = 9, shared with the HC595 serializers.
- One sub-module, `peak_abs_tracker`: abs stage, saturation, running max, sample counter, clip flag, and a clear input.
- The top level holds the FSM, index register, settle counter and status flags.

## Test plan
- **Reset:** assert `i_rst` mid-MEASURE → `o_att_idx` = 9, `o_locked` = 0, `o_peak` = 0 within the same cycle (async).
- **Step down:** sine of amplitude 300 at idx 9 with `i_en` = 1 → idx steps 9→8→…→0 with one SETTLE between each step. At 0, `o_range_err` = 1 and `o_locked` = 0.
- **Lock:** amplitude 1200 at idx 5 → after one window, `o_locked` = 1, `o_peak` = 1200, idx stays 5 and no SETTLE is entered.
- **Clip abort:** single sample −2048 at count 10 of a window at idx 3 → `o_peak` = 2047 and `o_att_idx` = 4 exactly 3 clocks later, then SETTLE.
- **Force:** `i_force` = 1, `i_force_idx` = 12 → `o_att_idx` = 9 the next clock and the FSM stays in SETTLE. Release force → SETTLE_CYC clocks pass before the first MEASURE sample is accepted.
- **Disable:** drop `i_en` at sample 2000 of a window → IDLE the next clock, index held, `o_peak` unchanged, `o_locked` = 0.

Source files
------------

// File: rtl/imp_pkg.sv
// ---------------------------------------------------------------------------
// imp_pkg
// Shared definitions for the attenuator path:
//   att_ar_state_t : auto-ranging FSM states (IDLE, SETTLE, MEASURE, DECIDE)
//   ATT_IDX_W      : width of an attenuation index
//   ATT_MAX_IDX    : highest legal attenuation index (60 dB)
//   clamp_idx()    : limits a requested index to a maximum
// ---------------------------------------------------------------------------
package imp_pkg;

   localparam int ATT_IDX_W   = 4;
   localparam int ATT_MAX_IDX = 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DECIDE  = 2'd3
   } att_ar_state_t;

   function automatic logic [ATT_IDX_W-1:0] clamp_idx(
      input logic [ATT_IDX_W-1:0] idx,
      input logic [ATT_IDX_W-1:0] max_idx
   );
      return (idx > max_idx) ? max_idx : idx;
   endfunction

endpackage

// File: rtl/peak_abs_tracker.sv
// ---------------------------------------------------------------------------
// peak_abs_tracker
// Window peak detector for a signed ADC stream.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : zero the running peak, sample count and clip flag
//   i_meas       : high while a window is being measured; samples are only
//                  captured and accumulated while it is high
//   i_valid      : sample strobe
//   i_data       : signed sample
//   o_peak       : saturated running maximum of |x|
//   o_clip       : the window was aborted by a clipping sample
//   o_done       : combinational, the sample now leaving the abs stage
//                  completes the window (count or clip)
// ---------------------------------------------------------------------------
module peak_abs_tracker #(
   parameter int ADC_W   = 12,
   parameter int WIN_LEN = 4096,
   parameter int CLIP_TH = 2040
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clear,
   input  logic             i_meas,
   input  logic             i_valid,
   input  logic [ADC_W-1:0] i_data,
   output logic [ADC_W-2:0] o_peak,
   output logic             o_clip,
   output logic             o_done
);

   localparam int MW    = ADC_W - 1;
   localparam int CNT_W = $clog2(WIN_LEN + 1);
   localparam logic [MW-1:0]    CLIP_V   = MW'(CLIP_TH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

   logic [MW-1:0]    mag;
   logic [MW-1:0]    abs_q, abs_d;
   logic             abs_vld_q, abs_vld_d;
   logic [MW-1:0]    peak_q, peak_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clip_q, clip_d;
   logic             take;
   logic             hit_clip;

   // |x| fits in ADC_W-1 bits for every code except the most negative one,
   // which saturates to all ones.
   always_comb begin
      mag = i_data[MW-1:0];
      if (i_data[ADC_W-1]) begin
         if (i_data[MW-1:0] == '0) begin
            mag = '1;
         end else begin
            mag = (~i_data[MW-1:0]) + MW'(1);
         end
      end
   end

   // A sample is only captured when it arrives during MEASURE, and only
   // accumulated if the FSM is still in MEASURE one clock later; anything in
   // flight when DECIDE fires is therefore dropped.
   assign abs_d     = mag;
   assign abs_vld_d = i_valid & i_meas;
   assign take      = abs_vld_q & i_meas;
   assign hit_clip  = (abs_q >= CLIP_V);
   assign o_done    = take & (hit_clip | (cnt_q == LAST_CNT));

   always_comb begin
      peak_d = peak_q;
      cnt_d  = cnt_q;
      clip_d = clip_q;
      if (i_clear) begin
         peak_d = '0;
         cnt_d  = '0;
         clip_d = 1'b0;
      end else if (take) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (hit_clip) begin
            peak_d = abs_q;
            clip_d = 1'b1;
         end else if (abs_q > peak_q) begin
            peak_d = abs_q;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         abs_q     <= '0;
         abs_vld_q <= 1'b0;
         peak_q    <= '0;
         cnt_q     <= '0;
         clip_q    <= 1'b0;
      end else begin
         abs_q     <= abs_d;
         abs_vld_q <= abs_vld_d;
         peak_q    <= peak_d;
         cnt_q     <= cnt_d;
         clip_q    <= clip_d;
      end
   end

   assign o_peak = peak_q;
   assign o_clip = clip_q;

endmodule

// File: rtl/att_autorange_ctrl.sv
// ---------------------------------------------------------------------------
// att_autorange_ctrl
// Auto-ranging controller for the B-channel input attenuator. Measures the
// window peak of the ADC stream and steps the attenuation index by one with
// hysteresis, waiting SETTLE_CYC clocks after every change.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : auto-ranging enable (low: IDLE, index holds)
//   i_adc_valid    : sample strobe
//   i_adc_data     : signed ADC sample
//   i_force        : manual override, highest priority
//   i_force_idx    : manual index, clamped to MAX_IDX
//   o_att_idx      : attenuation index to the HC595 serializer (i_ATT_B)
//   o_locked       : last window was in range and caused no change
//   o_range_err    : a window asked for a step past 0 or MAX_IDX (sticky)
//   o_peak         : peak magnitude of the last completed window
// ---------------------------------------------------------------------------
module att_autorange_ctrl
   import imp_pkg::*;
#(
   parameter int ADC_W      = 12,
   parameter int WIN_LEN    = 4096,
   parameter int SETTLE_CYC = 100000,
   parameter int HI_TH      = 1843,
   parameter int LO_TH      = 737,
   parameter int CLIP_TH    = 2040,
   parameter int MAX_IDX    = ATT_MAX_IDX
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_en,
   input  logic                 i_adc_valid,
   input  logic [ADC_W-1:0]     i_adc_data,
   input  logic                 i_force,
   input  logic [ATT_IDX_W-1:0] i_force_idx,
   output logic [ATT_IDX_W-1:0] o_att_idx,
   output logic                 o_locked,
   output logic                 o_range_err,
   output logic [ADC_W-2:0]     o_peak
);

   localparam int MW     = ADC_W - 1;
   localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
   localparam logic [SCNT_W-1:0]    SETTLE_LAST = SCNT_W'(SETTLE_CYC - 1);
   localparam logic [ATT_IDX_W-1:0] MAX_V       = ATT_IDX_W'(MAX_IDX);
   localparam logic [MW-1:0]        HI_V        = MW'(HI_TH);
   localparam logic [MW-1:0]        LO_V        = MW'(LO_TH);

   att_ar_state_t        state_q, state_d;
   logic [SCNT_W-1:0]    scnt_q, scnt_d;
   logic [ATT_IDX_W-1:0] idx_q, idx_d;
   logic                 locked_q, locked_d;
   logic                 err_q, err_d;
   logic [MW-1:0]        peak_q, peak_d;

   logic [MW-1:0]        trk_peak;
   logic                 trk_clip;
   logic                 trk_done;

   // Tracker state is held cleared whenever no window is open, so every
   // MEASURE entry starts from an empty window.
   peak_abs_tracker #(
      .ADC_W   (ADC_W),
      .WIN_LEN (WIN_LEN),
      .CLIP_TH (CLIP_TH)
   ) u_tracker (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (state_q != MEASURE),
      .i_meas  (state_q == MEASURE),
      .i_valid (i_adc_valid),
      .i_data  (i_adc_data),
      .o_peak  (trk_peak),
      .o_clip  (trk_clip),
      .o_done  (trk_done)
   );

   always_comb begin
      state_d  = state_q;
      scnt_d   = scnt_q;
      idx_d    = idx_q;
      locked_d = locked_q;
      err_d    = err_q;
      peak_d   = peak_q;

      if (i_force) begin
         // Park in SETTLE with a fresh count so release always gets a full settle.
         state_d  = SETTLE;
         scnt_d   = '0;
         idx_d    = clamp_idx(i_force_idx, MAX_V);
         locked_d = 1'b0;
      end else if (!i_en) begin
         state_d  = IDLE;
         scnt_d   = '0;
         locked_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = SETTLE;
               scnt_d  = '0;
            end
            SETTLE: begin
               if (scnt_q == SETTLE_LAST) begin
                  state_d = MEASURE;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + SCNT_W'(1);
               end
            end
            MEASURE: begin
               if (trk_done) begin
                  state_d = DECIDE;
               end
            end
            DECIDE: begin
               peak_d = trk_peak;
               if (trk_clip || (trk_peak >= HI_V)) begin
                  locked_d = 1'b0;
                  if (idx_q < MAX_V) begin
                     idx_d   = idx_q + ATT_IDX_W'(1);
                     state_d = SETTLE;
                     scnt_d  = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = MEASURE;
                  end
               end else if (trk_peak < LO_V) begin
                  locked_d = 1'b0;
                  if (idx_q != '0) begin
                     idx_d   = idx_q - ATT_IDX_W'(1);
                     state_d = SETTLE;
                     scnt_d  = '0;
                  end else begin
                     err_d   = 1'b1;
                     state_d = MEASURE;
                  end
               end else begin
                  locked_d = 1'b1;
                  err_d    = 1'b0;
                  state_d  = MEASURE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         scnt_q   <= '0;
         idx_q    <= MAX_V;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         peak_q   <= '0;
      end else begin
         state_q  <= state_d;
         scnt_q   <= scnt_d;
         idx_q    <= idx_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         peak_q   <= peak_d;
      end
   end

   assign o_att_idx   = idx_q;
   assign o_locked    = locked_q;
   assign o_range_err = err_q;
   assign o_peak      = peak_q;

endmodule

// File: tb/tb_att_autorange_ctrl.sv
module tb_att_autorange_ctrl;

   localparam int ADC_W = 12;
   localparam int W     = 32;
   localparam int S     = 12;
   localparam int HI    = 1843;
   localparam int LO    = 737;
   localparam int CLIP  = 2040;
   localparam int MAXI  = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             valid = 1'b0;
   logic [ADC_W-1:0] data = '0;
   logic             tb_force = 1'b0;
   logic [3:0]       fidx = '0;
   logic [3:0]       o_att_idx;
   logic             o_locked;
   logic             o_range_err;
   logic [ADC_W-2:0] o_peak;

   int checks = 0;
   int errors = 0;

   // Reference model state (what the outputs should be after each decision).
   int m_idx = MAXI;
   int m_err = 0;
   int m_locked = 0;
   int m_peak = 0;

   att_autorange_ctrl #(
      .ADC_W      (ADC_W),
      .WIN_LEN    (W),
      .SETTLE_CYC (S),
      .HI_TH      (HI),
      .LO_TH      (LO),
      .CLIP_TH    (CLIP),
      .MAX_IDX    (MAXI)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_en        (en),
      .i_adc_valid (valid),
      .i_adc_data  (data),
      .i_force     (tb_force),
      .i_force_idx (fidx),
      .o_att_idx   (o_att_idx),
      .o_locked    (o_locked),
      .o_range_err (o_range_err),
      .o_peak      (o_peak)
   );

   always #5 clk = ~clk;

   // Outputs are read and inputs driven 1 ns after each rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Clipping-level samples: any of these accepted outside a window shows up.
   task automatic junk();
      valid = 1'b1;
      data  = 12'h7FF;
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Drives one measurement window starting in the current cycle. Samples are
   // random with random gaps; one sample hits +/-amp exactly. clip_pos >= 0
   // puts a -2048 sample at that window position. Afterwards checks the
   // 3-clock decision latency, the outcome and, on a change, the settle gap.
   task automatic do_window(input int amp, input int clip_pos, input string tag);
      int cnt = 0;
      int pk = 0;
      bit clip = 1'b0;
      int v;
      int pk_pos;
      int old_idx;
      pk_pos  = $urandom_range(0, W - 1);
      old_idx = m_idx;
      while (cnt < W && !clip) begin
         if ($urandom_range(0, 3) != 0) begin
            if (cnt == clip_pos) begin
               v = -2048;
               clip = 1'b1;
            end else if (cnt == pk_pos) begin
               v = ($urandom_range(0, 1) != 0) ? amp : -amp;
            end else begin
               v = int'($urandom_range(0, 2 * amp - 2)) - (amp - 1);
            end
            if (!clip && iabs(v) > pk) pk = iabs(v);
            valid = 1'b1;
            data  = v[ADC_W-1:0];
            cnt++;
         end else begin
            valid = 1'b0;
            data  = 12'($urandom);
         end
         cycle();
      end
      junk();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (o_att_idx !== 4'(old_idx)) begin
            errors++;
            $display("FAIL %s_early_idx: got %0d expected %0d (clock %0d after last sample)",
                     tag, o_att_idx, old_idx, i + 1);
         end
         cycle();
      end
      m_peak = clip ? 2047 : pk;
      if (clip || pk >= HI) begin
         m_locked = 0;
         if (m_idx < MAXI) m_idx++;
         else m_err = 1;
      end else if (pk < LO) begin
         m_locked = 0;
         if (m_idx > 0) m_idx--;
         else m_err = 1;
      end else begin
         m_locked = 1;
         m_err = 0;
      end
      checks++;
      if (o_att_idx !== 4'(m_idx)) begin
         errors++;
         $display("FAIL %s_idx: got %0d expected %0d", tag, o_att_idx, m_idx);
      end
      checks++;
      if (o_locked !== 1'(m_locked)) begin
         errors++;
         $display("FAIL %s_locked: got %0d expected %0d", tag, o_locked, m_locked);
      end
      checks++;
      if (o_range_err !== 1'(m_err)) begin
         errors++;
         $display("FAIL %s_range_err: got %0d expected %0d", tag, o_range_err, m_err);
      end
      checks++;
      if (o_peak !== 11'(m_peak)) begin
         errors++;
         $display("FAIL %s_peak: got %0d expected %0d", tag, o_peak, m_peak);
      end
      $display("window %s: amp=%0d clip=%0d peak=%0d idx %0d->%0d locked=%0d err=%0d",
               tag, amp, clip, m_peak, old_idx, m_idx, m_locked, m_err);
      if (m_idx != old_idx) begin
         // Settling: junk samples must be ignored and the index must hold.
         for (int i = 0; i < S; i++) begin
            checks++;
            if (o_att_idx !== 4'(m_idx)) begin
               errors++;
               $display("FAIL %s_settle_idx: got %0d expected %0d", tag, o_att_idx, m_idx);
            end
            cycle();
         end
      end
   endtask

   // Forces an index, releases, and returns in the first MEASURE cycle.
   task automatic force_to(input int k);
      int exp_idx;
      exp_idx  = (k > MAXI) ? MAXI : k;
      tb_force = 1'b1;
      fidx     = 4'(k);
      junk();
      cycle();
      checks++;
      if (o_att_idx !== 4'(exp_idx)) begin
         errors++;
         $display("FAIL force_to_idx: got %0d expected %0d", o_att_idx, exp_idx);
      end
      repeat (3) cycle();
      m_idx    = exp_idx;
      m_locked = 0;
      tb_force = 1'b0;
      repeat (S) cycle();
      $display("force_to: idx=%0d", exp_idx);
   endtask

   task automatic test_reset();
      repeat (3) cycle();
      checks++;
      if (o_att_idx !== 4'd9) begin
         errors++;
         $display("FAIL reset_idx: got %0d expected 9", o_att_idx);
      end
      checks++;
      if (o_locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_locked: got %0d expected 0", o_locked);
      end
      checks++;
      if (o_range_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_range_err: got %0d expected 0", o_range_err);
      end
      checks++;
      if (o_peak !== 11'd0) begin
         errors++;
         $display("FAIL reset_peak: got %0d expected 0", o_peak);
      end
      rst = 1'b0;
      junk();
      repeat (W + S + 5) cycle();
      checks++;
      if (o_att_idx !== 4'd9 || o_peak !== 11'd0) begin
         errors++;
         $display("FAIL idle_hold: got idx=%0d peak=%0d expected idx=9 peak=0", o_att_idx, o_peak);
      end
      $display("test_reset done");
   endtask

   task automatic test_step_down();
      en = 1'b1;
      junk();
      repeat (S + 1) cycle();
      for (int i = 0; i < 10; i++) do_window(300, -1, "step_down");
      checks++;
      if (o_att_idx !== 4'd0 || o_range_err !== 1'b1 || o_locked !== 1'b0) begin
         errors++;
         $display("FAIL step_down_floor: got idx=%0d err=%0d locked=%0d expected idx=0 err=1 locked=0",
                  o_att_idx, o_range_err, o_locked);
      end
      do_window(1000, -1, "recover");
   endtask

   task automatic test_lock();
      force_to(5);
      do_window(1200, -1, "lock");
      checks++;
      if (o_locked !== 1'b1 || o_peak !== 11'd1200 || o_att_idx !== 4'd5) begin
         errors++;
         $display("FAIL lock_result: got locked=%0d peak=%0d idx=%0d expected 1 1200 5",
                  o_locked, o_peak, o_att_idx);
      end
      do_window(1200, -1, "lock_again");
   endtask

   task automatic test_thresholds();
      do_window(LO, -1, "at_lo");
      do_window(HI - 1, -1, "below_hi");
      do_window(LO - 1, -1, "below_lo");
      do_window(HI, -1, "at_hi");
   endtask

   task automatic test_clip();
      force_to(3);
      do_window(500, 10, "clip");
      checks++;
      if (o_peak !== 11'd2047 || o_att_idx !== 4'd4) begin
         errors++;
         $display("FAIL clip_result: got peak=%0d idx=%0d expected 2047 4", o_peak, o_att_idx);
      end
   endtask

   task automatic test_force();
      int pk0;
      int er0;
      pk0 = m_peak;
      er0 = m_err;
      tb_force = 1'b1;
      fidx = 4'd12;
      junk();
      cycle();
      checks++;
      if (o_att_idx !== 4'd9 || o_locked !== 1'b0) begin
         errors++;
         $display("FAIL force_clamp: got idx=%0d locked=%0d expected 9 0", o_att_idx, o_locked);
      end
      repeat (S + W + 6) cycle();
      checks++;
      if (o_att_idx !== 4'd9 || o_peak !== 11'(pk0) || o_range_err !== 1'(er0)) begin
         errors++;
         $display("FAIL force_hold: got idx=%0d peak=%0d err=%0d expected 9 %0d %0d",
                  o_att_idx, o_peak, o_range_err, pk0, er0);
      end
      m_idx = 9;
      m_locked = 0;
      tb_force = 1'b0;
      repeat (S) cycle();
      do_window(300, -1, "after_force");
   endtask

   task automatic test_random();
      int r;
      int amp;
      int cp;
      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 2);
         if (r == 0) amp = $urandom_range(1, LO - 1);
         else if (r == 1) amp = $urandom_range(LO, HI - 1);
         else amp = $urandom_range(HI, CLIP - 1);
         cp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1;
         do_window(amp, cp, "random");
      end
   endtask

   task automatic test_disable();
      do_window(1200, -1, "pre_disable");
      for (int i = 0; i < 20; i++) begin
         valid = 1'b1;
         data  = 12'd100;
         cycle();
      end
      en = 1'b0;
      junk();
      cycle();
      m_locked = 0;
      checks++;
      if (o_att_idx !== 4'(m_idx) || o_locked !== 1'b0 || o_peak !== 11'(m_peak)) begin
         errors++;
         $display("FAIL disable: got idx=%0d locked=%0d peak=%0d expected %0d 0 %0d",
                  o_att_idx, o_locked, o_peak, m_idx, m_peak);
      end
      repeat (S + W + 6) cycle();
      checks++;
      if (o_att_idx !== 4'(m_idx) || o_peak !== 11'(m_peak) || o_range_err !== 1'(m_err)) begin
         errors++;
         $display("FAIL disable_hold: got idx=%0d peak=%0d err=%0d expected %0d %0d %0d",
                  o_att_idx, o_peak, o_range_err, m_idx, m_peak, m_err);
      end
      $display("disable: idx=%0d held", m_idx);
      en = 1'b1;
      repeat (S + 1) cycle();
      do_window(1200, -1, "reenable");
   endtask

   task automatic test_reset_mid();
      force_to(2);
      do_window(1200, -1, "pre_reset");
      for (int i = 0; i < 10; i++) begin
         valid = 1'b1;
         data  = 12'd50;
         cycle();
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (o_att_idx !== 4'd9 || o_locked !== 1'b0 || o_peak !== 11'd0 || o_range_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got idx=%0d locked=%0d peak=%0d err=%0d expected 9 0 0 0",
                  o_att_idx, o_locked, o_peak, o_range_err);
      end
      m_idx = 9;
      m_locked = 0;
      m_err = 0;
      m_peak = 0;
      $display("reset_mid: outputs at reset values");
      cycle();
      rst = 1'b0;
      junk();
      repeat (S + 1) cycle();
      do_window(300, -1, "after_reset");
   endtask

   initial begin
      test_reset();
      test_step_down();
      test_lock();
      test_thresholds();
      test_clip();
      test_force();
      test_random();
      test_disable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
